// File: rtl/add_issue_pkg.sv
// Shared types and constants for the adder issue/capture stage.
package add_issue_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } issue_state_t;

endpackage

// File: rtl/add_issue_ctrl_settle_counter.sv
// Settle-window down-counter: loads a start value, counts down to zero and
// then sits at zero until the next load.
module settle_counter
    import add_issue_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/add_issue_ctrl.sv
// Valid/ready issue stage for the combinational carry-skip adder: holds the
// operands for SETTLE_CYCLES, then captures sum/carry. ADD_ISSUE_OVF_EN adds out_ovf.
module add_issue_ctrl
    import add_issue_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W-1:0] add_s,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
`ifdef ADD_ISSUE_OVF_EN
    output logic              out_ovf,
`endif
    output logic              busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    issue_state_t r_state;
    logic         w_in_fire;
    logic         w_cnt_zero;
    logic         w_cnt_dec;

    // A new pair is accepted from IDLE, or from HOLD on the same edge the result leaves.
    assign in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
    assign w_in_fire = in_valid && in_ready;
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign w_cnt_dec = (r_state == SETTLE);

    settle_counter #(
        .W(CNT_W)
    ) u_settle_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_in_fire),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            add_a    <= '0;
            add_b    <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
`ifdef ADD_ISSUE_OVF_EN
            out_ovf  <= 1'b0;
`endif
        end else begin
            if (w_in_fire) begin
                add_a <= in_a;
                add_b <= in_b;
            end
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_cnt_zero) begin
                        out_sum  <= add_s;
                        out_cout <= add_cout;
`ifdef ADD_ISSUE_OVF_EN
                        out_ovf  <= (add_a[DATA_W-1] == add_b[DATA_W-1]) &&
                                    (add_s[DATA_W-1] != add_a[DATA_W-1]);
`endif
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= in_valid ? SETTLE : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_issue_ctrl.sv
// Directed self-checking bench for add_issue_ctrl with a behavioural adder
// closing the add_a/add_b -> add_s/add_cout loop.
module tb_add_issue_ctrl;

    localparam int SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        busy;
`ifdef ADD_ISSUE_OVF_EN
    logic        out_ovf;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

    add_issue_ctrl #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef ADD_ISSUE_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one pair from IDLE; returns #1 after the accepting edge with junk on the inputs.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        checkOutput("ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic waitResult(input string tag, input logic [31:0] expSum, input logic expCout, input logic expOvf);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) checkOutput({tag, "_ready_in_settle"}, 64'(in_ready), 64'd0);
        end while (!out_valid && lat < 300);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(SETTLE));
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_sum"}, 64'(out_sum), 64'(expSum));
        checkOutput({tag, "_cout"}, 64'(out_cout), 64'(expCout));
`ifdef ADD_ISSUE_OVF_EN
        checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] unused overflow expectation");
`endif
    endtask

    task automatic consumeResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_after_consume"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_busy_after_consume"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pairA [4];
        logic [31:0] pairB [4];
        logic [31:0] expS  [4];
        logic        expC  [4];
        int          accCyc [4];
        int          sent;
        int          got;
        logic        fireIn;
        logic        fireOut;
        logic        sawValid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("valid_in_reset", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_sum", 64'(out_sum), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_add_a", 64'(add_a), 64'd0);

        applyStimulus(32'h0000_0005, 32'h0000_0003);
        waitResult("add_5_3", 32'h0000_0008, 1'b0, 1'b0);
        consumeResult("add_5_3");

        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001);
        waitResult("carry_skip", 32'h0000_0000, 1'b1, 1'b0);
        consumeResult("carry_skip");

        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001);
        waitResult("signed_ovf", 32'h8000_0000, 1'b0, 1'b1);
        consumeResult("signed_ovf");

        // Stall the result while a fresh pair waits on the input.
        applyStimulus(32'h1234_5678, 32'h1111_1111);
        waitResult("bp", 32'h2345_6789, 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_a      = 32'hDEAD_BEEF;
        in_b      = 32'hCAFE_F00D;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_sum", 64'(out_sum), 64'h2345_6789);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_add_a", 64'(add_a), 64'h1234_5678);
        end
        in_valid = 1'b0;
        consumeResult("bp");

        // Back-to-back: each pair is accepted on the edge that retires the previous result.
        pairA[0] = 32'h0000_0001; pairB[0] = 32'h0000_0002; expS[0] = 32'h0000_0003; expC[0] = 1'b0;
        pairA[1] = 32'hFFFF_FFFF; pairB[1] = 32'hFFFF_FFFF; expS[1] = 32'hFFFF_FFFE; expC[1] = 1'b1;
        pairA[2] = 32'h8000_0000; pairB[2] = 32'h8000_0000; expS[2] = 32'h0000_0000; expC[2] = 1'b1;
        pairA[3] = 32'hA5A5_A5A5; pairB[3] = 32'h5A5A_5A5A; expS[3] = 32'hFFFF_FFFF; expC[3] = 1'b0;
        sent      = 0;
        got       = 0;
        in_valid  = 1'b1;
        in_a      = pairA[0];
        in_b      = pairB[0];
        out_ready = 1'b1;
        for (int c = 0; c < 400 && got < 4; c++) begin
            @(negedge clk);
            fireIn  = in_valid && in_ready;
            fireOut = out_valid && out_ready;
            if (fireOut) begin
                checkOutput($sformatf("b2b_sum%0d", got), 64'(out_sum), 64'(expS[got]));
                checkOutput($sformatf("b2b_cout%0d", got), 64'(out_cout), 64'(expC[got]));
                checkOutput($sformatf("b2b_latency%0d", got), 64'(cyc - accCyc[got]), 64'(SETTLE));
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (fireIn) begin
                accCyc[sent] = cyc;
                sent++;
                if (sent < 4) begin
                    in_a = pairA[sent];
                    in_b = pairB[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checkOutput("b2b_result_count", 64'(got), 64'd4);
        out_ready = 1'b0;
        checkOutput("b2b_idle_busy", 64'(busy), 64'd0);

        // Reset three cycles into the settle window discards the transaction.
        applyStimulus(32'h0000_0011, 32'h0000_0022);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_add_a", 64'(add_a), 64'd0);
        checkOutput("midrst_add_b", 64'(add_b), 64'd0);
        checkOutput("midrst_sum", 64'(out_sum), 64'd0);
        checkOutput("midrst_cout", 64'(out_cout), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready_after", 64'(in_ready), 64'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midrst_no_valid", 64'(sawValid), 64'd0);
        applyStimulus(32'h0000_0100, 32'h0000_0200);
        waitResult("after_rst", 32'h0000_0300, 1'b0, 1'b0);
        consumeResult("after_rst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/add_issue_ctrl.md
# add_issue_ctrl

Handshaked issue/capture stage directly upstream of the 32-bit carry-skip adder. Accepts one operand pair per transaction on a valid/ready input port, holds it stable on the adder's operand inputs for a programmed settle window that covers the adder's worst-case ripple/skip delay, then samples the sum and carry-out into a result register presented on a valid/ready output port. It turns the purely combinational adder into a flow-controlled, back-pressurable pipeline element.

## Interface
- SETTLE_CYCLES, 16, clock cycles operands are held before the adder output is sampled; legal range 1..255
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept an operand pair this cycle
- in_a  input  32  operand A
- in_b  input  32  operand B
- add_a  output  32  registered operand A driven to adder `a`
- add_b  output  32  registered operand B driven to adder `b`
- add_s  input  32  adder sum `s`
- add_cout  input  1  adder `cout`
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  32  captured sum
- out_cout  output  1  captured carry-out
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready: load add_a/add_b from in_a/in_b, load counter with SETTLE_CYCLES-1, go SETTLE.
- SETTLE: in_ready=0, out_valid=0. Counter decrements each cycle; when counter==0, capture add_s→out_sum, add_cout→out_cout, go HOLD.
- HOLD: out_valid=1; out_sum/out_cout stable until handshake. in_ready = out_ready.
  - out_ready=0: stay HOLD, nothing changes.
  - out_ready=1 and in_valid=0: go IDLE.
  - out_ready=1 and in_valid=1: result consumed and new operands accepted on the same edge; go SETTLE (counter reloaded).
- add_a/add_b change only on an input handshake; never change during SETTLE.
- Arithmetic is unsigned mod 2^32; carry-in to the adder is tied 0 by the adder itself; out_cout is bit 32 of in_a+in_b.
- in_a/in_b are ignored when no handshake occurs.

## Timing
- Reset (async assert, sync release): state=IDLE, add_a=0, add_b=0, out_sum=0, out_cout=0, out_valid=0, counter=0; in_ready=1, busy=0 once reset is low.
- Input handshake at edge k → out_valid rises after edge k+SETTLE_CYCLES (latency SETTLE_CYCLES).
- SETTLE_CYCLES=1: sample on the first edge after accept.
- Peak throughput: one result per SETTLE_CYCLES cycles with out_ready held high (back-to-back via HOLD→SETTLE).
- Reset mid-SETTLE or mid-HOLD: transaction discarded, no out_valid pulse, all outputs return to reset values immediately.
- in_ready is combinational from state and out_ready only; out_valid is a pure function of state.

## Configuration
- ADD_ISSUE_OVF_EN defined: adds output port out_ovf (1 bit), captured alongside out_sum as signed two's-complement overflow = (add_a[31]==add_b[31]) && (add_s[31]!=add_a[31]); reset 0, held with out_sum.
- Undefined: port and logic absent; behaviour otherwise identical.

## Structure
- Shared package add_issue_pkg: DATA_W=32 localparam, state enum type (IDLE, SETTLE, HOLD), CNT_W=8 counter width constant.
- One sub-module natural: settle_counter (load, decrement, zero flag), instanced once.
- Adder is instanced by the parent alongside this block, not inside it.

## Test plan
- Reset then idle: after rst deassert, in_ready=1, out_valid=0, out_sum=0, busy=0.
- Single add, SETTLE_CYCLES=16: in_a=0x0000_0005, in_b=0x0000_0003 at edge k → out_valid at k+16, out_sum=0x0000_0008, out_cout=0.
- Carry-out / full skip: in_a=0xFFFF_FFFF, in_b=0x0000_0001 → out_sum=0x0000_0000, out_cout=1; with ADD_ISSUE_OVF_EN out_ovf=0; 0x7FFF_FFFF+0x0000_0001 → out_ovf=1.
- Backpressure: out_ready=0 for 20 cycles in HOLD → out_sum/out_valid stable, in_ready=0, add_a unchanged despite new in_a.
- Back-to-back: out_ready=1, in_valid=1 continuously with 4 pairs → 4 results spaced exactly SETTLE_CYCLES apart, in order, correct sums.
- Reset mid-SETTLE: assert rst 3 cycles after accept → out_valid never rises, all outputs 0, next transaction completes normally.
